// File: rtl/adder_serial_pkg.sv
// Shared definitions for the digit-serial adder/subtractor (adder_serial).
// FSM state encodings are plain 2-bit constants so the state register keeps
// its legacy bit layout; clog2 sizes the chunk counter.
package adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/adder_serial_chunk.sv
// adder_chunk: combinational CHUNK-bit full adder, {o_cout,o_sum} = a + b + cin.
// With ADDER_SERIAL_OVF_EN defined it also exports the carry into its MSB,
// which the top uses to derive signed overflow from the last chunk.
module adder_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] i_a,
    input  logic [CHUNK-1:0] i_b,
    input  logic             i_cin,
    output logic [CHUNK-1:0] o_sum,
    output logic             o_cout
`ifdef ADDER_SERIAL_OVF_EN
    ,
    output logic             o_cmsb
`endif
);

    logic [CHUNK:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
    assign o_sum  = w_full[CHUNK-1:0];
    assign o_cout = w_full[CHUNK];

`ifdef ADDER_SERIAL_OVF_EN
    // Sum bit = a ^ b ^ carry_in at the MSB, so the carry in is recovered by XOR.
    assign o_cmsb = i_a[CHUNK-1] ^ i_b[CHUNK-1] ^ w_full[CHUNK-1];
`endif

endmodule

// File: rtl/adder_serial.sv
// adder_serial: digit-serial multi-precision adder/subtractor.
// Operands are taken on a valid/ready handshake and added CHUNK bits per clock,
// LSB chunk first, with the carry held in a register between chunks.
// Subtraction is A + ~B + ~cin, so ocout = 1 means "no borrow".
// Optional feature macro: ADDER_SERIAL_OVF_EN adds the oovf signed-overflow port.
module adder_serial
    import adder_pkg::*;
#(
    parameter int unsigned MP_WIDTH = 32,
    parameter int unsigned CHUNK    = 8
) (
    input  logic                iclk,
    input  logic                irst,
    input  logic                ivalid,
    output logic                oready,
    input  logic [MP_WIDTH-1:0] ia,
    input  logic [MP_WIDTH-1:0] ib,
    input  logic                icin,
    input  logic                isub,
    output logic                ovalid,
    input  logic                iready,
    output logic [MP_WIDTH-1:0] osum,
    output logic                ocout
`ifdef ADDER_SERIAL_OVF_EN
    ,
    output logic                oovf
`endif
);

    localparam int unsigned NCHUNK = MP_WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (clog2(NCHUNK) > 0) ? clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if ((CHUNK == 0) || (MP_WIDTH % CHUNK != 0)) begin : g_bad_chunk
        $error("adder_serial: MP_WIDTH must be a non-zero multiple of CHUNK");
    end

    logic [1:0]          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [MP_WIDTH-1:0] r_a;
    logic [MP_WIDTH-1:0] r_b;
    logic                r_carry;
    logic [MP_WIDTH-1:0] r_osum;
    logic                r_ocout;
`ifdef ADDER_SERIAL_OVF_EN
    logic                r_oovf;
    logic                w_chunk_cmsb;
`endif

    logic [CHUNK-1:0]    w_chunk_sum;
    logic                w_chunk_cout;
    logic [MP_WIDTH-1:0] w_a_next;
    logic [MP_WIDTH-1:0] w_b_next;
    logic                w_last;
    logic                w_accept;

    assign oready   = (r_state == ST_IDLE);
    assign ovalid   = (r_state == ST_DONE);
    assign osum     = r_osum;
    assign ocout    = r_ocout;
`ifdef ADDER_SERIAL_OVF_EN
    assign oovf     = r_oovf;
`endif

    assign w_accept = (r_state == ST_IDLE) && ivalid;
    assign w_last   = (r_cnt == LAST_CNT);

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .i_a    (r_a[CHUNK-1:0]),
        .i_b    (r_b[CHUNK-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_chunk_sum),
        .o_cout (w_chunk_cout)
`ifdef ADDER_SERIAL_OVF_EN
        ,
        .o_cmsb (w_chunk_cmsb)
`endif
    );

    // The A register doubles as the partial-sum shift register: each result
    // chunk enters at the top as the consumed A chunk leaves at the bottom,
    // so after NCHUNK shifts it holds the complete sum.
    if (NCHUNK == 1) begin : g_single
        assign w_a_next = w_chunk_sum;
    end else begin : g_multi
        assign w_a_next = {w_chunk_sum, r_a[MP_WIDTH-1:CHUNK]};
    end

    assign w_b_next = r_b >> CHUNK;

    // FSM sequencing IDLE -> RUN -> DONE -> IDLE and the chunk counter
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ivalid) begin
                        r_state <= ST_RUN;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (iready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Operand capture, per-chunk operand/sum shifting and the inter-chunk carry
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_a     <= ia;
            r_b     <= isub ? ~ib : ib;
            r_carry <= icin ^ isub;
        end else if (r_state == ST_RUN) begin
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_carry <= w_chunk_cout;
        end
    end

    // Result registers, loaded only on the RUN -> DONE transition
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_osum  <= '0;
            r_ocout <= 1'b0;
`ifdef ADDER_SERIAL_OVF_EN
            r_oovf  <= 1'b0;
`endif
        end else if ((r_state == ST_RUN) && w_last) begin
            r_osum  <= w_a_next;
            r_ocout <= w_chunk_cout;
`ifdef ADDER_SERIAL_OVF_EN
            r_oovf  <= w_chunk_cmsb ^ w_chunk_cout;
`endif
        end
    end

endmodule

// File: tb/tb_adder_serial.sv
// Directed, table-driven bench for adder_serial (MP_WIDTH=32, CHUNK=8), plus a
// second instance with CHUNK=32 for the single-cycle case. Overflow checks are
// compiled in only when ADDER_SERIAL_OVF_EN is defined.
module tb_adder_serial;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    logic        iclk;
    logic        irst;

    logic        ivalid;
    logic        oready;
    logic [31:0] ia;
    logic [31:0] ib;
    logic        icin;
    logic        isub;
    logic        ovalid;
    logic        iready;
    logic [31:0] osum;
    logic        ocout;

    logic        ivalid1;
    logic        oready1;
    logic [31:0] ia1;
    logic [31:0] ib1;
    logic        icin1;
    logic        isub1;
    logic        ovalid1;
    logic        iready1;
    logic [31:0] osum1;
    logic        ocout1;

`ifdef ADDER_SERIAL_OVF_EN
    logic        oovf;
    logic        oovf1;
`endif

    int n_checks;
    int n_errors;

    logic [31:0] g_sum_in_run;
    logic        g_ready_in_run;
    logic        g_valid_at_accept;

    adder_serial #(
        .MP_WIDTH (32),
        .CHUNK    (8)
    ) u_dut (
        .iclk   (iclk),
        .irst   (irst),
        .ivalid (ivalid),
        .oready (oready),
        .ia     (ia),
        .ib     (ib),
        .icin   (icin),
        .isub   (isub),
        .ovalid (ovalid),
        .iready (iready),
        .osum   (osum),
        .ocout  (ocout)
`ifdef ADDER_SERIAL_OVF_EN
        ,
        .oovf   (oovf)
`endif
    );

    adder_serial #(
        .MP_WIDTH (32),
        .CHUNK    (32)
    ) u_dut1 (
        .iclk   (iclk),
        .irst   (irst),
        .ivalid (ivalid1),
        .oready (oready1),
        .ia     (ia1),
        .ib     (ib1),
        .icin   (icin1),
        .isub   (isub1),
        .ovalid (ovalid1),
        .iready (iready1),
        .osum   (osum1),
        .ocout  (ocout1)
`ifdef ADDER_SERIAL_OVF_EN
        ,
        .oovf   (oovf1)
`endif
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (actual=timeout required=finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Launch one operation on u_dut and wait (bounded) for ovalid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic sub, output int lat);
        int w;
        w = 0;
        @(negedge iclk);
        while (!oready && w < 40) begin
            @(negedge iclk);
            w++;
        end
        ia = a; ib = b; icin = cin; isub = sub; ivalid = 1'b1;
        @(posedge iclk);
        #1;
        ivalid = 1'b0; ia = '0; ib = '0; icin = 1'b0; isub = 1'b0;
        g_sum_in_run      = osum;
        g_ready_in_run    = oready;
        g_valid_at_accept = ovalid;
        lat = 0;
        do begin
            @(posedge iclk);
            #1;
            lat++;
        end while (!ovalid && lat < 20);
    endtask

    task automatic drain();
        @(negedge iclk);
        iready = 1'b1;
        @(posedge iclk);
        #1;
        iready = 1'b0;
    endtask

    initial begin
        vec_t vecs[10];
        int   lat;
        int   bad;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 1'b0, 32'h0100_0101, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0010, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_000A, 1'b1, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
        vecs[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

        n_checks = 0;
        n_errors = 0;
        irst = 1'b1;
        ivalid = 1'b0; ia = '0; ib = '0; icin = 1'b0; isub = 1'b0; iready = 1'b0;
        ivalid1 = 1'b0; ia1 = '0; ib1 = '0; icin1 = 1'b0; isub1 = 1'b0; iready1 = 1'b0;

        // Reset state
        #22;
        check("rst_oready", oready, 1'b1);
        check("rst_ovalid", ovalid, 1'b0);
        check("rst_osum",   osum,   32'h0);
        check("rst_ocout",  ocout,  1'b0);
`ifdef ADDER_SERIAL_OVF_EN
        check("rst_oovf",   oovf,   1'b0);
`endif
        @(negedge iclk);
        irst = 1'b0;

        // Table-driven operations
        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, lat);
            check($sformatf("v%0d_latency", i), lat, 4);
            check($sformatf("v%0d_osum", i), osum, vecs[i].sum);
            check($sformatf("v%0d_ocout", i), ocout, vecs[i].cout);
`ifdef ADDER_SERIAL_OVF_EN
            check($sformatf("v%0d_oovf", i), oovf, vecs[i].ovf);
`endif
            if (i == 0) begin
                check("run_oready_low", g_ready_in_run, 1'b0);
                check("accept_ovalid_low", g_valid_at_accept, 1'b0);
            end
            if (i > 0) begin
                check($sformatf("v%0d_osum_held_in_run", i), g_sum_in_run, vecs[i-1].sum);
            end
            drain();
            check($sformatf("v%0d_drain_ovalid", i), ovalid, 1'b0);
            check($sformatf("v%0d_drain_oready", i), oready, 1'b1);
        end

        // DONE held with iready=0 while new operands are offered
        run_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, lat);
        check("hold_osum", osum, 32'h3333_3333);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge iclk);
            ivalid = 1'b1; ia = 32'hFFFF_FFFF; ib = 32'hFFFF_FFFF; icin = 1'b1;
            @(posedge iclk);
            #1;
            if (!ovalid || oready || osum !== 32'h3333_3333 || ocout !== 1'b0) bad++;
        end
        ivalid = 1'b0; ia = '0; ib = '0; icin = 1'b0;
        check("hold_bad_cycles", bad, 0);
        drain();
        check("hold_idle_osum_kept", osum, 32'h3333_3333);
        run_op(32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0, lat);
        check("after_hold_run_osum_kept", g_sum_in_run, 32'h3333_3333);
        check("after_hold_osum", osum, 32'h0000_000B);
        drain();

        // Reset in the middle of RUN aborts the operation
        @(negedge iclk);
        ia = 32'hAAAA_AAAA; ib = 32'h5555_5555; icin = 1'b1; ivalid = 1'b1;
        @(posedge iclk);
        #1;
        ivalid = 1'b0; ia = '0; ib = '0; icin = 1'b0;
        @(posedge iclk);
        @(posedge iclk);
        #2;
        irst = 1'b1;
        #1;
        check("midrst_oready", oready, 1'b1);
        check("midrst_ovalid", ovalid, 1'b0);
        check("midrst_osum",   osum,   32'h0);
        check("midrst_ocout",  ocout,  1'b0);
        @(negedge iclk);
        irst = 1'b0;
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge iclk);
            #1;
            if (ovalid || !oready) bad++;
        end
        check("midrst_no_partial", bad, 0);
        run_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, lat);
        check("midrst_next_latency", lat, 4);
        check("midrst_next_osum", osum, 32'h0000_0003);
        drain();

        // Single-chunk instance: one RUN cycle
        @(negedge iclk);
        ia1 = 32'h1234_5678; ib1 = 32'h1111_1111; icin1 = 1'b1; isub1 = 1'b0; ivalid1 = 1'b1;
        @(posedge iclk);
        #1;
        ivalid1 = 1'b0; ia1 = '0; ib1 = '0; icin1 = 1'b0;
        lat = 0;
        do begin
            @(posedge iclk);
            #1;
            lat++;
        end while (!ovalid1 && lat < 20);
        check("c32_latency", lat, 1);
        check("c32_osum", osum1, 32'h2345_678A);
        check("c32_ocout", ocout1, 1'b0);
`ifdef ADDER_SERIAL_OVF_EN
        check("c32_oovf", oovf1, 1'b0);
`endif
        @(negedge iclk);
        iready1 = 1'b1;
        @(posedge iclk);
        #1;
        iready1 = 1'b0;
        check("c32_drain_oready", oready1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
